// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg: bus-state encodings, default timing constants and strobe index names
// shared by the sequencer and the downstream DRAM/register logic.
package phase_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_P1 = 3'd1, S_P2 = 3'd2, S_P3 = 3'd3,
    S_P4   = 3'd4, S_P5 = 3'd5, S_P6 = 3'd6, S_P7 = 3'd7
  } bus_state_e;
  localparam int REF_PERIOD_DEF = 13;
  localparam int LOCK_CNT_DEF   = 4;
  localparam int STALL_MAX_DEF  = 3;
  localparam int STB_IDLE = 0;
  localparam int STB_P1   = 1;
  localparam int STB_P2   = 2;
  localparam int STB_P3   = 3;
  localparam int STB_P4   = 4;
  localparam int STB_P5   = 5;
  localparam int STB_P6   = 6;
  localparam int STB_P7   = 7;
endpackage

// File: rtl/phase_sequencer_refresh_divider.sv
// refresh_divider: counts bus cycles modulo REF_PERIOD and requests a DRAM refresh
// during S==1 of every REF_PERIOD-th bus cycle, starting with the first.
module refresh_divider
  import phase_sequencer_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_adv,
  input  logic i_s1,
  output logic o_req
);
  logic [3:0] r_ref;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ref <= '0;
    else if (i_adv) r_ref <= (r_ref == 4'(REF_PERIOD - 1)) ? '0 : r_ref + 4'd1;
  assign o_req = i_s1 & (r_ref == '0);
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: locks to PHI1 on C7M, generates bus state S, phase strobes, bus enables,
// refresh request and lock/glitch health indication.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int STALL_MAX  = STALL_MAX_DEF
) (
  input  logic       C7M,
  input  logic       nRES,
  input  logic       PHI1,
  input  logic       nWE,
  output logic [2:0] S,
  output logic [7:0] SOH,
  output logic       DBEN,
  output logic       CSEN,
  output logic       RefReq,
  output logic       Locked,
  output logic       Glitch
);
  bus_state_e r_s, w_s_next;
  logic       r_phi1, r_phi0_seen, r_dben, r_csen, r_locked, r_glitch;
  logic [3:0] r_lock_cnt, r_stall;
  logic       w_edge, w_wf, w_bad, w_stall;

  assign w_edge  = PHI1 & ~r_phi1 & r_phi0_seen;
  assign w_wf    = w_edge & (r_s >= S_P6);
  // The very first edge after reset arrives from S_IDLE and is not a malformed period.
  assign w_bad   = w_edge & (r_s <= S_P5) & ~((r_s == S_IDLE) & ~r_locked);
  assign w_stall = r_stall > 4'(STALL_MAX);

  always_comb
    w_s_next = w_edge ? S_P1 : (r_s == S_IDLE) ? S_IDLE : (r_s == S_P7) ? S_P7 : bus_state_e'(r_s + 3'd1);

  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) r_s <= S_IDLE;
    else r_s <= w_s_next;

  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) begin
      r_phi1      <= 1'b0;
      r_phi0_seen <= 1'b0;
      r_dben      <= 1'b0;
      r_csen      <= 1'b0;
      r_glitch    <= 1'b0;
      r_stall     <= '0;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_phi1      <= PHI1;
      r_phi0_seen <= r_phi0_seen | ~PHI1;
      r_dben      <= r_s >= S_P4;
      r_csen      <= ((r_s == S_P4) & nWE) | (r_s >= S_P5);
      r_glitch    <= w_bad;
      r_stall     <= w_edge ? '0 : ((r_s == S_P7) && r_stall != 4'hF) ? r_stall + 4'd1 : r_stall;
      r_lock_cnt  <= w_bad ? '0 : w_wf ? ((r_lock_cnt >= 4'(LOCK_CNT)) ? r_lock_cnt : r_lock_cnt + 4'd1)
                   : w_stall ? '0 : r_lock_cnt;
      r_locked    <= w_bad ? 1'b0 : (w_wf && r_lock_cnt >= 4'(LOCK_CNT - 1)) ? 1'b1
                   : w_stall ? 1'b0 : r_locked;
    end

  refresh_divider #(.REF_PERIOD(REF_PERIOD)) u_ref (
    .i_clk   (C7M),
    .i_rst_n (nRES),
    .i_adv   ((r_s == S_P3) & ~w_edge),
    .i_s1    (r_s == S_P1),
    .o_req   (RefReq)
  );

  assign S      = r_s;
  assign SOH    = 8'd1 << r_s;
  assign DBEN   = r_dben;
  assign CSEN   = r_csen;
  assign Locked = r_locked;
  assign Glitch = r_glitch;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized PHI1 waveforms checked against an event-level model
// that tracks time since the last PHI1 edge, period lengths and bus-cycle counts.
module tb_phase_sequencer;
  localparam int REF = 13, LOCK = 4, STALLM = 3;
  logic       C7M = 1'b0, nRES = 1'b1, PHI1 = 1'b1, nWE = 1'b1;
  logic [2:0] S;
  logic [7:0] SOH;
  logic       DBEN, CSEN, RefReq, Locked, Glitch;
  int         n_chk = 0, n_pass = 0;
  bit         m_sync, m_prev_phi1, m_seen0, m_locked, m_dben, m_csen, m_glitch;
  int         m_age, m_s3_passes, m_good;

  phase_sequencer #(.REF_PERIOD(REF), .LOCK_CNT(LOCK), .STALL_MAX(STALLM)) dut (
    .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .nWE(nWE), .S(S), .SOH(SOH),
    .DBEN(DBEN), .CSEN(CSEN), .RefReq(RefReq), .Locked(Locked), .Glitch(Glitch)
  );

  always #5 C7M = ~C7M;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  function automatic int exp_s();
    return m_sync ? ((m_age > 7) ? 7 : m_age) : 0;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_prev_phi1 = 0; m_seen0 = 0; m_locked = 0; m_dben = 0; m_csen = 0;
    m_glitch = 0; m_age = 0; m_s3_passes = 0; m_good = 0;
  endtask

  task automatic model_step(input bit phi1, input bit nwe);
    int  cur;
    bit  edge_, bad, wf, stall;
    cur   = exp_s();
    edge_ = phi1 && !m_prev_phi1 && m_seen0;
    bad   = edge_ && m_sync && m_age <= 5;
    wf    = edge_ && m_sync && m_age >= 6;
    stall = m_sync && !edge_ && (m_age - 7) > STALLM;
    m_glitch = bad;
    m_dben   = cur >= 4;
    m_csen   = (cur == 4 && nwe) || cur >= 5;
    if (bad) begin m_good = 0; m_locked = 0; end
    else if (wf) begin
      if (m_good < LOCK) m_good++;
      if (m_good == LOCK) m_locked = 1;
    end else if (stall) begin m_good = 0; m_locked = 0; end
    if (cur == 3 && !edge_) m_s3_passes++;
    if (edge_) begin m_sync = 1; m_age = 1; end
    else if (m_sync && m_age < 1000) m_age++;
    m_prev_phi1 = phi1;
    if (!phi1) m_seen0 = 1;
  endtask

  task automatic check_all();
    int s;
    s = exp_s();
    check("S", 8'(S), 8'(s));
    check("SOH", SOH, 8'd1 << s);
    check("DBEN", 8'(DBEN), 8'(m_dben));
    check("CSEN", 8'(CSEN), 8'(m_csen));
    check("RefReq", 8'(RefReq), 8'(s == 1 && (m_s3_passes % REF) == 0));
    check("Locked", 8'(Locked), 8'(m_locked));
    check("Glitch", 8'(Glitch), 8'(m_glitch));
  endtask

  task automatic cycle(input bit phi1);
    PHI1 = phi1;
    nWE  = 1'($urandom_range(0, 1));
    @(posedge C7M);
    if (nRES) model_step(phi1, nWE);
    @(negedge C7M);
    check_all();
  endtask

  task automatic period(input int p, input int lo);
    for (int i = 0; i < p; i++) cycle(i >= lo);
  endtask

  initial begin
    int p, lo;
    model_reset();
    #1 nRES = 1'b0;
    #1 check("rst_S", 8'(S), 8'd0);
    @(negedge C7M);
    check_all();
    nRES = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1);
    for (int i = 0; i < 30; i++) period(7, 4);
    check("locked_after_train", 8'(Locked), 8'd1);
    period(4, 1);
    period(3, 1);
    for (int i = 0; i < 6; i++) period(7, 3);
    period(8, 4);
    check("long_keeps_lock", 8'(Locked), 8'd1);
    for (int i = 0; i < 15; i++) cycle(1'b1);
    check("stall_drops_lock", 8'(Locked), 8'd0);
    for (int i = 0; i < 250; i++) begin
      p  = ($urandom_range(0, 9) < 7) ? 7 : $urandom_range(2, 9);
      lo = $urandom_range(1, p - 1);
      period(p, lo);
      if ($urandom_range(0, 29) == 0) for (int j = 0; j < 12; j++) cycle(1'b1);
    end
    for (int i = 0; i < 5; i++) period(7, 4);
    for (int i = 0; i < 7 && exp_s() != 5; i++) cycle(i < 3 ? 1'b0 : 1'b1);
    check("pre_reset_S5", 8'(S), 8'd5);
    #2 nRES = 1'b0;
    model_reset();
    #1 check("async_S", 8'(S), 8'd0);
    check("async_DBEN", 8'(DBEN), 8'd0);
    check("async_CSEN", 8'(CSEN), 8'd0);
    check("async_Locked", 8'(Locked), 8'd0);
    @(negedge C7M);
    cycle(1'b1);
    nRES = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1);
    for (int i = 0; i < 40; i++) period(7, $urandom_range(1, 6));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Upstream timing stage for the card's DRAM/ROM/register logic.
- Locks to the Apple II PHI1 clock (already delay-qualified) on the C7M clock and produces the 3-bit bus state counter S plus decoded phase strobes.
- Also produces the registered data-bus and ROM chip-select gating enables, a DRAM refresh request, and a lock/health indication.
- Downstream RAS/CAS, register-write and address-increment logic consume S and these enables directly.

Parameters:
- REF_PERIOD, 13: bus cycles per refresh slot; legal range 2-16.
- LOCK_CNT, 4: consecutive well-formed PHI1 periods required to assert Locked; legal range 1-15.
- STALL_MAX, 3: C7M cycles S may sit at 7 before lock is dropped.

Ports:
- C7M  input  1  7.16 MHz bus clock; all state on rising edge.
- nRES  input  1  asynchronous active-low reset.
- PHI1  input  1  qualified PHI1; asynchronous to C7M within -20/+10 ns.
- nWE  input  1  6502 R/W (1 = read).
- S  output  3  bus state; 0 = unsynchronised, 1..7 = phase position.
- SOH  output  8  one-hot decode of S; combinational from S.
- DBEN  output  1  Apple II / RD data bus drive enable.
- CSEN  output  1  ROM chip-select gating enable.
- RefReq  output  1  high for the whole S==1 state of a refresh cycle.
- Locked  output  1  sequencer tracking a regular PHI1.
- Glitch  output  1  one-C7M pulse on a malformed PHI1 period.

Behaviour:
- Clock and reset: one clock (C7M); reset is asynchronous and active-low (nRES).
- Reset values: every register, including PHI1reg, PHI0seen, Ref and lock/stall counters, is 0. Outputs after reset: S=0, SOH=8'h01, DBEN=0, CSEN=0, RefReq=0, Locked=0, Glitch=0.
- PHI1reg <= PHI1 on every edge. PHI0seen <= 1 on any edge sampling PHI1==0; it is cleared only by reset.
- Edge is defined as PHI1 & ~PHI1reg & PHI0seen.
- S next-state, in priority order:
  - Edge -> 1.
  - S==0 -> 0.
  - S==7 -> 7 (saturate; covers the 8-cycle long bus cycle).
  - Otherwise S+1.
- Normal period is 7 C7M cycles; the long cycle holds S==7 for 2 cycles.
- Ref (4-bit):
  - On the edge where S==3: Ref <= (Ref==REF_PERIOD-1) ? 0 : Ref+1.
  - RefReq = (S==1) & (Ref==0). It is registered-state derived and glitch-free.
  - The first refresh occurs in the first S==1 after reset.
- DBEN <= S in {4,5,6,7} (one-cycle registered lag of S).
- CSEN <= (S==4 & nWE) | S in {5,6,7}.
- Stall counter counts cycles with S==7 and no Edge; it clears on Edge.
- Lock counter:
  - Edge with prior S in {6,7}: increment, saturating at LOCK_CNT.
  - Locked <= 1 when the count reaches LOCK_CNT.
- Malformed period: Edge with prior S in {0..5}, excluding the first Edge (prior S==0 while Locked==0).
  - Glitch pulses 1 cycle.
  - Lock counter <= 0; Locked <= 0.
  - S still resyncs to 1.
- Stall: when the stall counter exceeds STALL_MAX, Locked <= 0 and the lock counter <= 0. S stays 7 until the next Edge; no Glitch.
- Simultaneous Edge and S==3: Edge wins (S->1) and Ref does not advance.
- Reset mid-cycle: all outputs drop immediately (async). DBEN/CSEN are never driven during or after reset until S reaches 4 again, which requires a PHI0 low then an Edge.

Decomposition:
- Shared package holds:
  - State encodings: S_IDLE=0, S_P1=1 .. S_P7=7.
  - Default constants for REF_PERIOD, LOCK_CNT, STALL_MAX.
  - The S==n strobe index names used by downstream DRAM/register logic.
- One natural sub-module: refresh_divider (Ref counter plus RefReq decode), parameterised by REF_PERIOD.

Test Plan:
1. Reset, hold PHI1=1 for 20 cycles, then a normal 7-cycle PHI1 waveform -> S stays 0 until PHI1 low is seen. After the first rising edge S runs 1..7. Locked=1 after the 4th well-formed edge, with no Glitch.
2. Steady 7-cycle periods, nWE=1 -> DBEN high exactly in the cycles after S=4..7 (4 cycles/period). CSEN identical. With nWE=0, CSEN high 3 cycles/period (after S=5..7).
3. 26 consecutive bus cycles -> RefReq high in bus cycle 1 and bus cycle 14 only, each for exactly 1 C7M cycle during S==1.
4. Inject a PHI1 rising edge when S==3 while Locked -> Glitch pulses once, Locked=0, S=1 next cycle. Ref unchanged on that cycle. Relock after 4 normal periods.
5. Insert one 8-cycle long period -> S reads 7 for 2 cycles, no Glitch, Locked stays 1. Stop PHI1 (held high) -> Locked drops after S==7 persists more than 3 cycles.
6. Assert nRES low while S==5 and DBEN=1 -> S, DBEN, CSEN and Locked go to 0 immediately. After release, no DBEN until PHI1 low and then an Edge and S reaches 4.
